i2c_eeprom_slave_sync: RTL and testbench

// - Synchronous I2C slave modelling a byte-addressed serial EEPROM for the SoC I2C master tests.
// - Oversamples SCL/SDA with the system clock; drives SDA open-drain low only.
// - Sits behind the board-level I2C pad buffer on the shared scl/sda bus (external pull-ups).

---
 rtl/i2c_eeprom_slave_sync.sv | 150 +++++++++++++++
 tb/tb_i2c_eeprom_slave_sync.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_slave_sync.sv
// i2c_eeprom_slave_sync: oversampled I2C EEPROM slave model; optional write protect via I2C_EEPROM_WP_EN
module i2c_eeprom_slave_sync #(
  parameter logic [6:0] ADDRESS = 7'b1010_000,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst_ni,
`ifdef I2C_EEPROM_WP_EN
  input  logic wp_i,
`endif
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe_o,
  output logic busy_o
);
  typedef enum logic [3:0] {IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RACK} state_t;
  state_t state_q, state_d;
  logic [2:0] scl_q, scl_d, sda_q, sda_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, shift_in, rd_now, rd_next;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic oe_q, oe_d, busy_q, busy_d, we, wp_on;
  logic scl_rise, scl_fall, start, stop, last, rd_start;
  logic [7:0] mem_q [2**ADDR_W];
`ifdef I2C_EEPROM_WP_EN
  assign wp_on = wp_i;
`else
  assign wp_on = 1'b0;
`endif
  assign scl_d = {scl_q[1:0], scl_i};
  assign sda_d = {sda_q[1:0], sda_i};
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign shift_in = {sh_q[6:0], sda_q[1]};
  assign last = cnt_q == 4'd7;
  assign ptr_inc = ptr_q + 1'b1;
  assign rd_now = mem_q[ptr_q];
  assign rd_next = mem_q[ptr_inc];
  assign rd_start = (state_q == DEV_ACK) & sh_q[0];
  assign sda_oe_o = oe_q;
  assign busy_o = busy_q;
  // Next-state logic: START/STOP override, bits captured on SCL rise, SDA changed on SCL fall
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    ptr_d = ptr_q;
    oe_d = oe_q;
    busy_d = busy_q;
    we = 1'b0;
    if (start) begin
      state_d = DEV;
      cnt_d = 4'd0;
      oe_d = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      cnt_d = 4'd0;
      oe_d = 1'b0;
      busy_d = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        DEV, WADDR, WDATA: begin
          sh_d = shift_in;
          cnt_d = cnt_q + 4'd1;
          if (last && state_q == DEV) begin
            state_d = shift_in[7:1] == ADDRESS ? DEV_ACK : IDLE;
            busy_d = shift_in[7:1] == ADDRESS;
            cnt_d = shift_in[7:1] == ADDRESS ? 4'd8 : 4'd0;
          end else if (last && state_q == WADDR) begin
            ptr_d = shift_in[ADDR_W-1:0];
            state_d = WADDR_ACK;
          end else if (last) begin
            we = ~wp_on;
            ptr_d = ptr_inc;
            state_d = WDATA_ACK;
          end
        end
        RDATA: begin
          cnt_d = cnt_q + 4'd1;
          state_d = last ? RACK : RDATA;
        end
        RACK: begin
          state_d = sda_q[1] ? IDLE : RACK;
          busy_d = busy_q & ~sda_q[1];
          cnt_d = sda_q[1] ? 4'd0 : cnt_q;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        DEV_ACK, WADDR_ACK, WDATA_ACK: begin
          if (cnt_q == 4'd8) begin
            oe_d = 1'b1;
            cnt_d = 4'd9;
          end else begin
            cnt_d = 4'd0;
            oe_d = rd_start ? ~rd_now[7] : 1'b0;
            sh_d = rd_start ? rd_now : sh_q;
            state_d = state_q == DEV_ACK ? (sh_q[0] ? RDATA : WADDR) : WDATA;
          end
        end
        RDATA: begin
          sh_d = {sh_q[6:0], sh_q[7]};
          oe_d = ~sh_q[6];
        end
        RACK: begin
          if (cnt_q == 4'd8) begin
            oe_d = 1'b0;
            cnt_d = 4'd9;
          end else begin
            ptr_d = ptr_inc;
            sh_d = rd_next;
            oe_d = ~rd_next[7];
            cnt_d = 4'd0;
            state_d = RDATA;
          end
        end
        default: ;
      endcase
    end
  end
  // State, synchronizer and pointer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      scl_q <= 3'b111;
      sda_q <= 3'b111;
      cnt_q <= 4'd0;
      sh_q <= 8'd0;
      ptr_q <= '0;
      oe_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scl_q <= scl_d;
      sda_q <= sda_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      ptr_q <= ptr_d;
      oe_q <= oe_d;
      busy_q <= busy_d;
    end
  end
  // Byte storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (we) mem_q[ptr_q] <= shift_in;
  end
endmodule

// File: tb/tb_i2c_eeprom_slave_sync.sv
// tb_i2c_eeprom_slave_sync: bit-banged I2C master with a reference memory/pointer model
`timescale 1ns/1ps
module tb_i2c_eeprom_slave_sync;
  localparam int Q = 6;
  logic clk = 1'b0, rst_ni = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_oe_o, busy_o, sda_i;
  int nchk = 0, nfail = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] ref_ptr = 8'd0;
  logic [7:0] wbuf [4];
  assign sda_i = sda_m & ~sda_oe_o;
  always #5 clk = ~clk;
  i2c_eeprom_slave_sync dut (
    .clk(clk), .rst_ni(rst_ni), .scl_i(scl_m), .sda_i(sda_i),
    .sda_oe_o(sda_oe_o), .busy_o(busy_o)
  );
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic i2c_start();
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
  endtask
  task automatic bit_x(input logic b, output logic s);
    sda_m = b; tick(Q); scl_m = 1'b1; tick(Q); s = sda_i; tick(Q); scl_m = 1'b0; tick(Q);
  endtask
  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, s);
    ack = ~s;
  endtask
  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      d[i] = s;
    end
    bit_x(~mack, s);
  endtask
  task automatic wr_txn(input logic [7:0] a, input int n);
    logic ak;
    i2c_start();
    wr_byte(8'hA0, ak); check("w_dev_ack", {7'd0, ak}, 8'd1);
    check("w_busy", {7'd0, busy_o}, 8'd1);
    wr_byte(a, ak); check("w_addr_ack", {7'd0, ak}, 8'd1);
    for (int i = 0; i < n; i++) begin
      wr_byte(wbuf[i], ak); check("w_data_ack", {7'd0, ak}, 8'd1);
      ref_mem[a + 8'(i)] = wbuf[i];
    end
    i2c_stop();
    check("w_stop_busy", {7'd0, busy_o}, 8'd0);
    ref_ptr = a + 8'(n);
  endtask
  task automatic rd_txn(input logic [7:0] a, input int n);
    logic ak;
    logic [7:0] d, p;
    i2c_start();
    wr_byte(8'hA0, ak); check("r_dev_ack", {7'd0, ak}, 8'd1);
    wr_byte(a, ak); check("r_addr_ack", {7'd0, ak}, 8'd1);
    i2c_start();
    wr_byte(8'hA1, ak); check("r_rdev_ack", {7'd0, ak}, 8'd1);
    p = a;
    for (int i = 0; i < n; i++) begin
      rd_byte(i < n - 1, d);
      check("rd_data", d, ref_mem[p]);
      if (i < n - 1) p = p + 8'd1;
    end
    check("rd_release", {7'd0, sda_oe_o}, 8'd0);
    check("rd_nack_busy", {7'd0, busy_o}, 8'd0);
    i2c_stop();
    ref_ptr = p;
  endtask
  task automatic cur_rd();
    logic ak;
    logic [7:0] d;
    i2c_start();
    wr_byte(8'hA1, ak); check("c_dev_ack", {7'd0, ak}, 8'd1);
    rd_byte(1'b0, d);
    check("cur_data", d, ref_mem[ref_ptr]);
    i2c_stop();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic ak, s;
    logic [7:0] a, dv;
    int n;
    tick(5);
    rst_ni = 1'b1;
    tick(2);
    check("rst_oe", {7'd0, sda_oe_o}, 8'd0);
    check("rst_busy", {7'd0, busy_o}, 8'd0);
    wbuf[0] = 8'h55; wbuf[1] = 8'hAA;
    wr_txn(8'h10, 2);
    rd_txn(8'h10, 2);
    i2c_start();
    wr_byte(8'hA2, ak);
    check("mismatch_ack", {7'd0, ak}, 8'd0);
    check("mismatch_busy", {7'd0, busy_o}, 8'd0);
    i2c_stop();
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    wr_txn(8'hFF, 2);
    rd_txn(8'hFF, 2);
    wbuf[0] = 8'h77; wbuf[1] = 8'h88;
    wr_txn(8'h30, 2);
    i2c_start();
    wr_byte(8'hA0, ak); check("p_dev_ack", {7'd0, ak}, 8'd1);
    wr_byte(8'h31, ak); check("p_addr_ack", {7'd0, ak}, 8'd1);
    for (int i = 0; i < 4; i++) bit_x(i[0], s);
    i2c_stop();
    check("p_busy", {7'd0, busy_o}, 8'd0);
    check("p_oe", {7'd0, sda_oe_o}, 8'd0);
    ref_ptr = 8'h31;
    cur_rd();
    for (int it = 0; it < 5; it++) begin
      a = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      wr_txn(a, n);
      rd_txn(a, n);
      cur_rd();
    end
    i2c_start();
    dv = 8'hA0;
    for (int i = 7; i >= 0; i--) bit_x(dv[i], s);
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(2);
    check("ack_before_rst", {7'd0, sda_oe_o}, 8'd1);
    rst_ni = 1'b0;
    tick(1);
    rst_ni = 1'b1;
    check("rst_mid_oe", {7'd0, sda_oe_o}, 8'd0);
    check("rst_mid_busy", {7'd0, busy_o}, 8'd0);
    tick(Q); scl_m = 1'b0; tick(Q);
    i2c_stop();
    ref_ptr = 8'd0;
    cur_rd();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
